// File: rtl/fetch_sequencer.sv
// Program-counter sequencer: walks the instruction ROM from a start pulse until the halt word
// or the last address, honouring stalls and taken branches, and counts the cycles spent running.
module fetch_sequencer #(
   parameter int                  PC_W       = 8,
   parameter int                  INSTR_W    = 9,
   parameter logic [INSTR_W-1:0]  HALT_WORD  = 9'h1FF,
   parameter logic [PC_W-1:0]     START_ADDR = '0,
   parameter int                  CNT_W      = 16
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               start_i,
   input  logic [INSTR_W-1:0] instr_i,
   input  logic               stall_i,
   input  logic               branch_taken_i,
   input  logic [PC_W-1:0]    branch_target_i,
   output logic [PC_W-1:0]    pc_o,
   output logic               instr_valid_o,
   output logic               running_o,
   output logic               done_o,
   output logic               fault_o,
   output logic [CNT_W-1:0]   cycle_count_o
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      HALTED = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [PC_W-1:0]   pc_q, pc_d;
   logic [CNT_W-1:0]  cycleCnt_q, cycleCnt_d;
   logic              fault_q, fault_d;

   logic isHalt;
   logic pcAtLast;
   logic cntAtMax;

   assign isHalt   = (instr_i == HALT_WORD);
   assign pcAtLast = (pc_q == {PC_W{1'b1}});
   assign cntAtMax = (cycleCnt_q == {CNT_W{1'b1}});

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q    <= IDLE;
         pc_q       <= '0;
         cycleCnt_q <= '0;
         fault_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         cycleCnt_q <= cycleCnt_d;
         fault_q    <= fault_d;
      end
   end

   // In RUN the branches below are a strict priority chain: stall, halt word, branch, overflow, step.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      cycleCnt_d = cycleCnt_q;
      fault_d    = fault_q;
      case (state_q)
         IDLE, HALTED: begin
            if (start_i) begin
               state_d    = RUN;
               pc_d       = START_ADDR;
               cycleCnt_d = '0;
               fault_d    = 1'b0;
            end
         end
         RUN: begin
            if (!cntAtMax) begin
               cycleCnt_d = cycleCnt_q + CNT_W'(1);
            end
            if (stall_i) begin
               pc_d = pc_q;
            end else if (isHalt) begin
               state_d = HALTED;
            end else if (branch_taken_i) begin
               pc_d = branch_target_i;
            end else if (pcAtLast) begin
               state_d = HALTED;
               fault_d = 1'b1;
            end else begin
               pc_d = pc_q + PC_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign pc_o          = pc_q;
   assign running_o     = (state_q == RUN);
   assign done_o        = (state_q == HALTED);
   assign fault_o       = fault_q;
   assign cycle_count_o = cycleCnt_q;
   assign instr_valid_o = running_o & ~stall_i & ~isHalt;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboarded bench for fetch_sequencer: directed program scenarios plus randomized runs against
// a per-cycle behavioural model of the sequencer's program-execution rules.
module tb_fetch_sequencer;

   localparam int M_IDLE   = 0;
   localparam int M_RUN    = 1;
   localparam int M_HALTED = 2;
   localparam logic [8:0] HALT = 9'h1FF;

   typedef struct {
      logic [7:0]  pc;
      logic        iv;
      logic        run;
      logic        dn;
      logic        flt;
      logic [15:0] cnt;
   } exp_t;

   logic        clk;
   logic        resetI;
   logic        startI;
   logic [8:0]  instrI;
   logic        stallI;
   logic        branchI;
   logic [7:0]  targetI;
   logic [7:0]  pcO;
   logic        ivO;
   logic        runO;
   logic        doneO;
   logic        faultO;
   logic [15:0] cntO;

   logic [8:0]  rom [256];
   exp_t        expQ [$];

   int          total;
   int          bad;

   int          mMode;
   int          mPc;
   int          mCnt;
   bit          mFault;

   fetch_sequencer dut (
      .clk_i           (clk),
      .reset_i         (resetI),
      .start_i         (startI),
      .instr_i         (instrI),
      .stall_i         (stallI),
      .branch_taken_i  (branchI),
      .branch_target_i (targetI),
      .pc_o            (pcO),
      .instr_valid_o   (ivO),
      .running_o       (runO),
      .done_o          (doneO),
      .fault_o         (faultO),
      .cycle_count_o   (cntO)
   );

   assign instrI = rom[pcO];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
      total++;
      if (actual !== required) begin
         bad++;
         $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, actual, required, $time);
      end
   endtask

   // Drive one cycle of inputs, queue what the outputs must show this cycle, then advance the model.
   task automatic applyStimulus(input logic rst, input logic st, input logic stl,
                                input logic br, input logic [7:0] tgt);
      exp_t e;
      @(negedge clk);
      resetI  = rst;
      startI  = st;
      stallI  = stl;
      branchI = br;
      targetI = tgt;
      e.pc  = 8'(mPc);
      e.run = (mMode == M_RUN);
      e.dn  = (mMode == M_HALTED);
      e.flt = mFault;
      e.cnt = 16'(mCnt);
      e.iv  = e.run && !stl && (rom[mPc] != HALT);
      expQ.push_back(e);
      if (rst) begin
         mMode = M_IDLE; mPc = 0; mCnt = 0; mFault = 0;
      end else if (mMode != M_RUN) begin
         if (st) begin
            mMode = M_RUN; mPc = 0; mCnt = 0; mFault = 0;
         end
      end else begin
         mCnt = (mCnt < 65535) ? mCnt + 1 : 65535;
         if (stl) begin
            mPc = mPc;
         end else if (rom[mPc] == HALT) begin
            mMode = M_HALTED;
         end else if (br) begin
            mPc = int'(tgt);
         end else if (mPc == 255) begin
            mMode = M_HALTED; mFault = 1;
         end else begin
            mPc = mPc + 1;
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 8'h00);
   endtask

   // Two reset cycles guarantee the DUT is not running when the ROM contents change.
   task automatic loadRom(input int haltAt, input bit randomFill);
      applyStimulus(1, 0, 0, 0, 8'h00);
      applyStimulus(1, 0, 0, 0, 8'h00);
      for (int i = 0; i < 256; i++) begin
         rom[i] = randomFill ? 9'($urandom_range(0, 510)) : 9'h000;
      end
      if (haltAt >= 0) rom[haltAt] = HALT;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput("pc", 32'(pcO), 32'(e.pc));
            checkOutput("instr_valid", 32'(ivO), 32'(e.iv));
            checkOutput("running", 32'(runO), 32'(e.run));
            checkOutput("done", 32'(doneO), 32'(e.dn));
            checkOutput("fault", 32'(faultO), 32'(e.flt));
            checkOutput("cycle_count", 32'(cntO), 32'(e.cnt));
         end
      end
   end

   initial begin : watchdog
      #1_000_000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] simulation time limit reached");
   end

   initial begin : stimulus
      total = 0; bad = 0;
      mMode = M_IDLE; mPc = 0; mCnt = 0; mFault = 0;
      resetI = 1; startI = 0; stallI = 0; branchI = 0; targetI = 0;
      for (int i = 0; i < 256; i++) rom[i] = HALT;
      $display("[TB] basic three-instruction program");
      loadRom(2, 0);
      for (int i = 3; i < 256; i++) rom[i] = HALT;
      applyStimulus(0, 1, 0, 0, 8'h00);
      idle(6);

      $display("[TB] stall held at pc=1");
      loadRom(10, 0);
      applyStimulus(0, 1, 0, 0, 8'h00);
      applyStimulus(0, 0, 0, 0, 8'h00);
      for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, 1, 8'h33);
      idle(15);

      $display("[TB] branches and self-loop");
      loadRom(40, 0);
      applyStimulus(0, 1, 0, 0, 8'h00);
      idle(2);
      applyStimulus(0, 0, 0, 1, 8'h05);
      idle(1);
      applyStimulus(0, 0, 0, 1, 8'h02);
      for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 1, 8'h02);
      idle(45);

      $display("[TB] branch on halt word");
      loadRom(2, 0);
      applyStimulus(0, 1, 0, 0, 8'h00);
      idle(2);
      applyStimulus(0, 0, 0, 1, 8'h10);
      for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 1, 8'h20);

      $display("[TB] run off the end of the ROM");
      loadRom(-1, 1);
      applyStimulus(0, 1, 0, 0, 8'h00);
      idle(20);
      for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 0, 8'h00);
      idle(240);

      $display("[TB] branch to the last address");
      loadRom(-1, 0);
      applyStimulus(0, 1, 0, 0, 8'h00);
      applyStimulus(0, 0, 0, 1, 8'hFF);
      idle(4);
      applyStimulus(0, 1, 0, 0, 8'h00);
      idle(3);

      $display("[TB] reset mid-run then restart");
      loadRom(50, 0);
      applyStimulus(0, 1, 0, 0, 8'h00);
      idle(3);
      applyStimulus(1, 0, 0, 0, 8'h00);
      idle(2);
      applyStimulus(0, 1, 0, 0, 8'h00);
      idle(10);

      $display("[TB] randomized programs");
      for (int p = 0; p < 4; p++) begin
         loadRom(-1, 1);
         for (int i = 0; i < 256; i++) if ($urandom_range(0, 39) == 0) rom[i] = HALT;
         for (int c = 0; c < 600; c++) begin
            applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, 19) == 0,
                          $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
                          8'($urandom_range(0, 255)));
         end
      end

      @(negedge clk);
      #3;
      checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
